rvfpm_issuer: RTL and testbench
===============================

Name: rvfpm_issuer

Overview:
- Core-side issue controller for the rvfpm coprocessor: the initiator end of the FPU instruction port (enable/fpu_ready/instruction).
- Buffers instructions from the core or test sequencer in a small FIFO, assigns each issued instruction a transaction ID, and presents instructions to the FPU under a valid/ready handshake.
- Tracks outstanding IDs until the FPU returns a result for that ID. Used in the integrated core model and as the active driver in the rvfpm bench.

Parameters:
- X_ID_WIDTH, 4, width of transaction ID.
- QUEUE_DEPTH, 4, issue FIFO entries (power of two, ≥2).
- PIPELINE_STAGES, 4, FPU pipeline depth; sets the outstanding limit.
- MAX_OUTSTANDING, PIPELINE_STAGES+QUEUE_DEPTH, maximum issued-not-retired IDs. Must be ≤ 2**X_ID_WIDTH.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  core offers an instruction.
- in_ready  out  1  FIFO can accept.
- in_instr  in  32  instruction word.
- flush  in  1  discard all unissued FIFO entries.
- enable  out  1  instruction valid toward FPU.
- fpu_ready  in  1  FPU accepts this cycle.
- instruction  out  32  instruction toward FPU.
- instr_id  out  X_ID_WIDTH  ID of presented instruction.
- result_valid  in  1  FPU retires an ID.
- result_id  in  X_ID_WIDTH  retired ID.
- outstanding_cnt  out  $clog2(MAX_OUTSTANDING+1)  issued-not-retired count.
- idle  out  1  FIFO empty and outstanding_cnt==0.
- spurious_result  out  1  sticky: retire of a non-outstanding ID.

Behaviour:
- Reset (rst low, async): FIFO emptied; outstanding bitmap cleared; next_id=0.
  - Outputs: enable=0, instruction=0, instr_id=0, outstanding_cnt=0, spurious_result=0, idle=1, in_ready=1.
- Push: in_valid && in_ready at edge writes in_instr to the FIFO tail.
  - in_ready = !full && !flush.
  - No bypass: a push in cycle N is presented on enable at N+1 at the earliest.
- Present: enable = !empty && !flush && !busy[next_id] && outstanding_cnt<MAX_OUTSTANDING.
  - instruction = FIFO head; instr_id = next_id.
  - When enable is low, instruction and instr_id hold their last values; they are 0 after reset.
- Issue: enable && fpu_ready at edge.
  - Pop head; set busy[next_id]; next_id increments mod 2**X_ID_WIDTH.
  - While enable is high without fpu_ready, instruction and instr_id stay stable. enable is never withdrawn except by flush or reset.
- Retire: result_valid at edge.
  - If busy[result_id], clear it.
  - Otherwise set spurious_result; it clears only on reset.
- outstanding_cnt: +1 on issue, -1 on valid retire, unchanged when both occur in the same cycle.
  - An issue and a retire of the same ID cannot coincide, because an ID is only issued when free.
- Full FIFO: in_ready=0, and push is ignored even if in_valid. A simultaneous push and issue when full is not allowed, because in_ready is already low.
- Empty FIFO with push and no pop: the entry appears at the head next cycle.
- ID stall: when next_id is still busy (wrap-around with an old ID unretired), enable=0 until that ID retires. IDs are never skipped.
- Flush: has precedence. enable=0 and in_ready=0 that cycle; FIFO pointers reset at the edge.
  - Busy bitmap, next_id and outstanding_cnt are unaffected; in-flight instructions still retire.
- Counters and pointers wrap modulo their width. The FIFO uses extra-bit pointers for full/empty.

Decomposition:
- Package rvfpm_issue_pkg:
  - instr_t (32-bit word).
  - id_t (X_ID_WIDTH).
  - localparams for pointer and count widths.
- Sub-module rvfpm_issue_fifo:
  - Synchronous FIFO with push/pop/flush, full/empty and head output.
- The top holds the ID allocator, busy bitmap, counter and handshake logic.

Test Plan:
- Reset then push 0x00A50553 with fpu_ready=1 → enable high next cycle, instr_id=0, instruction=0x00A50553; outstanding_cnt=1 after the edge; idle=0.
- Push 5 instructions with fpu_ready=0 and QUEUE_DEPTH=4 → in_ready low after 4 pushes, 5th not accepted; enable high with a stable head for 10 cycles; then fpu_ready=1 → 4 issues with IDs 0..3 in order.
- Issue 8 instructions without retiring → 9th stalls with enable=0 at outstanding_cnt=8. Retire ID 3 → count 7, but the next ID is 8, free, so issue resumes.
- Issue 16 instructions, retire IDs 1..15 and not 0 → the 17th waits on ID 0 with enable=0. Retire ID 0 → issued next cycle with instr_id=0.
- Same-cycle issue of ID 2 and retire of ID 1 → outstanding_cnt unchanged. Retire of never-issued ID 9 → spurious_result=1 and stays 1 until reset.
- With 3 queued and 2 outstanding, assert flush → next cycle FIFO empty, enable=0, outstanding_cnt=2. Retire both → idle=1. Assert rst low mid-stall → all outputs at reset values immediately.

Source files
------------

// File: rtl/rvfpm_issue_pkg.sv
// Shared types and sizing for the rvfpm issue controller.
// Holds the ID/queue/outstanding sizing, the derived pointer and counter
// widths, and the word/ID types used on the issuer's ports.
package rvfpm_issue_pkg;

    localparam int unsigned X_ID_WIDTH      = 4;
    localparam int unsigned QUEUE_DEPTH     = 4;
    localparam int unsigned PIPELINE_STAGES = 4;
    localparam int unsigned MAX_OUTSTANDING = PIPELINE_STAGES + QUEUE_DEPTH;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned NUM_IDS = 1 << X_ID_WIDTH;
    localparam int unsigned ADDR_W  = $clog2(QUEUE_DEPTH);
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [INSTR_W-1:0]    instr_t;
    typedef logic [X_ID_WIDTH-1:0] id_t;
    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    // Payload last presented to the FPU; held while enable is low.
    typedef struct packed {
        instr_t instr;
        id_t    id;
    } issue_t;

endpackage

// File: rtl/rvfpm_issuer_if.sv
// Core-side and FPU-side signal bundle of the rvfpm issue controller.
//   master : the issuer (accepts core instructions, drives the FPU port)
//   slave  : the environment (core/sequencer and FPU model)
// Signals: in_valid/in_ready/in_instr/flush (core side),
//          enable/fpu_ready/instruction/instr_id (FPU issue),
//          result_valid/result_id (FPU retire),
//          outstanding_cnt/idle/spurious_result (status).
interface rvfpm_issuer_if;
    import rvfpm_issue_pkg::*;

    logic   in_valid;
    logic   in_ready;
    instr_t in_instr;
    logic   flush;
    logic   enable;
    logic   fpu_ready;
    instr_t instruction;
    id_t    instr_id;
    logic   result_valid;
    id_t    result_id;
    cnt_t   outstanding_cnt;
    logic   idle;
    logic   spurious_result;

    modport master (
        input  in_valid, in_instr, flush, fpu_ready, result_valid, result_id,
        output in_ready, enable, instruction, instr_id, outstanding_cnt, idle,
               spurious_result
    );

    modport slave (
        output in_valid, in_instr, flush, fpu_ready, result_valid, result_id,
        input  in_ready, enable, instruction, instr_id, outstanding_cnt, idle,
               spurious_result
    );

endinterface

// File: rtl/rvfpm_issue_fifo.sv
// Synchronous instruction FIFO for the rvfpm issuer.
// Ports: ck, rst (async active-low), push/wdata (write tail),
//        pop (advance head), flush (empty at the edge),
//        head (current head word), full, empty.
// Extra-bit read/write pointers distinguish full from empty.
module rvfpm_issue_fifo
    import rvfpm_issue_pkg::*;
(
    input  logic   ck,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  instr_t wdata,
    output instr_t head,
    output logic   full,
    output logic   empty
);

    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    instr_t mem [QUEUE_DEPTH];
    logic   do_push;
    logic   do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign head  = mem[rd_ptr[ADDR_W-1:0]];

    // Pointer update; flush discards every queued entry.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    // Storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge ck) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/rvfpm_issuer.sv
// rvfpm issue controller: buffers core instructions, tags each issued
// instruction with a transaction ID and presents it to the FPU under an
// enable/fpu_ready handshake, tracking IDs until the FPU retires them.
// Ports: ck (rising edge), rst (async active-low), bus (rvfpm_issuer_if.master).
module rvfpm_issuer
    import rvfpm_issue_pkg::*;
(
    input logic            ck,
    input logic            rst,
    rvfpm_issuer_if.master bus
);

    logic               push;
    logic               issue;
    logic               enable_c;
    logic               retire_ok;
    logic               full;
    logic               empty;
    instr_t             head;
    id_t                next_id;
    logic [NUM_IDS-1:0] busy;
    logic [NUM_IDS-1:0] busy_d;
    cnt_t               cnt;
    logic               spurious;
    issue_t             hold_q;

    rvfpm_issue_fifo u_fifo (
        .ck    (ck),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .flush (bus.flush),
        .wdata (bus.in_instr),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Handshake qualification; flush masks both sides in its cycle.
    assign bus.in_ready = !full && !bus.flush;
    assign push         = bus.in_valid && bus.in_ready;
    assign enable_c     = !empty && !bus.flush && !busy[next_id] &&
                          (cnt < CNT_W'(MAX_OUTSTANDING));
    assign issue        = enable_c && bus.fpu_ready;
    assign retire_ok    = bus.result_valid && busy[bus.result_id];

    // Busy bitmap next state; an ID is only issued while free, so the
    // set and clear never target the same bit in one cycle.
    always_comb begin
        busy_d = busy;
        if (retire_ok) busy_d[bus.result_id] = 1'b0;
        if (issue)     busy_d[next_id]       = 1'b1;
    end

    // ID allocator, outstanding counter, sticky error and presented payload.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            next_id  <= '0;
            busy     <= '0;
            cnt      <= '0;
            spurious <= 1'b0;
            hold_q   <= '0;
        end else begin
            busy <= busy_d;
            if (issue) next_id <= next_id + id_t'(1);
            case ({issue, retire_ok})
                2'b10:   cnt <= cnt + cnt_t'(1);
                2'b01:   cnt <= cnt - cnt_t'(1);
                default: cnt <= cnt;
            endcase
            if (bus.result_valid && !busy[bus.result_id]) spurious <= 1'b1;
            if (enable_c) hold_q <= '{instr: head, id: next_id};
        end
    end

    // While enable is low the last presented instruction/ID is held.
    assign bus.enable          = enable_c;
    assign bus.instruction     = enable_c ? head : hold_q.instr;
    assign bus.instr_id        = enable_c ? next_id : hold_q.id;
    assign bus.outstanding_cnt = cnt;
    assign bus.idle            = empty && (cnt == '0);
    assign bus.spurious_result = spurious;

endmodule

// File: tb/tb_rvfpm_issuer.sv
// Self-checking bench for rvfpm_issuer: directed scenarios followed by
// random traffic, every cycle compared against a queue-based model.
module tb_rvfpm_issuer;

    logic ck;
    logic rst;
    int   n_err;
    int   n_checks;

    rvfpm_issuer_if bus ();

    rvfpm_issuer dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus.master)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Model state: pending instructions, outstanding IDs in issue order.
    logic [31:0] m_q[$];
    int          m_out[$];
    int          m_next;
    bit          m_spur;
    logic [31:0] m_last_instr;
    int          m_last_id;

    // Snapshot of DUT outputs taken at the last per-cycle check point.
    logic        s_en, s_rdy, s_idle, s_spur;
    logic [3:0]  s_id, s_cnt;
    logic [31:0] s_ins;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_out(input int id);
        foreach (m_out[k]) if (m_out[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_out.delete();
        m_next       = 0;
        m_spur       = 1'b0;
        m_last_instr = '0;
        m_last_id    = 0;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic fl,
                          input logic rdy, input logic rv, input logic [3:0] rid);
        bus.in_valid     = v;
        bus.in_instr     = ins;
        bus.flush        = fl;
        bus.fpu_ready    = rdy;
        bus.result_valid = rv;
        bus.result_id    = rid;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic fl,
                       input logic rdy, input logic rv, input logic [3:0] rid);
        bit exp_rdy;
        bit exp_en;
        int idx;
        set_in(v, ins, fl, rdy, rv, rid);
        #1;
        exp_rdy = (m_q.size() < 4) && !fl;
        exp_en  = (m_q.size() > 0) && !fl && !is_out(m_next) && (m_out.size() < 8);
        if (exp_en) begin
            m_last_instr = m_q[0];
            m_last_id    = m_next;
        end
        s_en = bus.enable; s_rdy = bus.in_ready; s_id = bus.instr_id;
        s_ins = bus.instruction; s_cnt = bus.outstanding_cnt;
        s_idle = bus.idle; s_spur = bus.spurious_result;
        chk("in_ready", 32'(s_rdy), 32'(exp_rdy));
        chk("enable", 32'(s_en), 32'(exp_en));
        chk("instruction", s_ins, m_last_instr);
        chk("instr_id", 32'(s_id), 32'(m_last_id));
        chk("outstanding_cnt", 32'(s_cnt), 32'(m_out.size()));
        chk("idle", 32'(s_idle), 32'((m_q.size() == 0) && (m_out.size() == 0)));
        chk("spurious_result", 32'(s_spur), 32'(m_spur));
        if (rv) begin
            idx = -1;
            foreach (m_out[k]) if (m_out[k] == int'(rid)) idx = k;
            if (idx >= 0) m_out.delete(idx);
            else m_spur = 1'b1;
        end
        if (exp_en && rdy) begin
            void'(m_q.pop_front());
            m_out.push_back(m_next);
            m_next = (m_next + 1) % 16;
        end
        if (fl) m_q.delete();
        else if (v && exp_rdy) m_q.push_back(ins);
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        model_reset();
        @(posedge ck);
        #1;
        rst = 1'b1;
    endtask

    // Retire the oldest outstanding ID each cycle until everything drains.
    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (m_out.size() > 0) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'(m_out[0]));
            else                  cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    initial begin
        logic        v, fl, rdy, rv;
        logic [3:0]  rid;
        logic [31:0] ins;
        n_err    = 0;
        n_checks = 0;
        rst      = 1'b0;
        model_reset();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        chk("rst_enable", 32'(bus.enable), 32'd0);
        chk("rst_instruction", bus.instruction, 32'd0);
        chk("rst_instr_id", 32'(bus.instr_id), 32'd0);
        chk("rst_cnt", 32'(bus.outstanding_cnt), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_spurious", 32'(bus.spurious_result), 32'd0);
        @(posedge ck);
        #1;
        rst = 1'b1;

        // First push appears on the FPU port one cycle later with ID 0.
        cyc(1'b1, 32'h00A50553, 1'b0, 1'b1, 1'b0, '0);
        chk("t1_no_bypass", 32'(s_en), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t1_enable", 32'(s_en), 32'd1);
        chk("t1_id", 32'(s_id), 32'd0);
        chk("t1_instr", s_ins, 32'h00A50553);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t1_cnt", 32'(s_cnt), 32'd1);
        chk("t1_idle", 32'(s_idle), 32'd0);
        drain();

        // Fill the FIFO with the FPU stalled, then release it.
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'h1000 + 32'(k), 1'b0, 1'b0, 1'b0, '0);
        chk("t2_full_in_ready", 32'(s_rdy), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
            chk("t2_stall_instr", s_ins, 32'h1000);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
            chk("t2_issue_id", 32'(s_id), 32'(k));
            chk("t2_issue_instr", s_ins, 32'h1000 + 32'(k));
        end
        drain();

        // Outstanding limit stalls issue; a retire of an older ID frees it.
        do_reset();
        for (int k = 0; k < 14; k++) cyc(1'b1, 32'h2000 + 32'(k), 1'b0, 1'b1, 1'b0, '0);
        chk("t3_cnt_max", 32'(s_cnt), 32'd8);
        chk("t3_stall", 32'(s_en), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd3);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t3_cnt_after", 32'(s_cnt), 32'd7);
        chk("t3_resume", 32'(s_en), 32'd1);
        chk("t3_resume_id", 32'(s_id), 32'd8);
        drain();

        // Wrap-around: ID 0 still busy blocks the 17th issue.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            rv = 1'b0;
            rid = '0;
            foreach (m_out[j]) if (!rv && m_out[j] != 0) begin
                rv = 1'b1;
                rid = 4'(m_out[j]);
            end
            cyc(1'b1, 32'h3000 + 32'(k), 1'b0, 1'b1, rv, rid);
        end
        chk("t4_id_stall", 32'(s_en), 32'd0);
        chk("t4_cnt", 32'(s_cnt), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t4_reissue", 32'(s_en), 32'd1);
        chk("t4_reissue_id", 32'(s_id), 32'd0);
        drain();

        // Same-cycle issue and retire, then a spurious retire.
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h4000 + 32'(k), 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd1);
        chk("t5_issue_id2", 32'(s_id), 32'd2);
        chk("t5_cnt_before", 32'(s_cnt), 32'd2);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd9);
        chk("t5_cnt_same", 32'(s_cnt), 32'd2);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t5_spurious", 32'(s_spur), 32'd1);

        // Flush discards queued work but keeps in-flight IDs.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h5000 + 32'(k), 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, '0);
        chk("t6_flush_en", 32'(s_en), 32'd0);
        chk("t6_flush_rdy", 32'(s_rdy), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t6_post_en", 32'(s_en), 32'd0);
        chk("t6_post_cnt", 32'(s_cnt), 32'd2);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'd2);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("t6_idle", 32'(s_idle), 32'd1);
        chk("t6_spur_sticky", 32'(s_spur), 32'd1);

        // Asynchronous reset in the middle of a stalled presentation.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h6000 + 32'(k), 1'b0, 1'b0, 1'b0, '0);
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_enable", 32'(bus.enable), 32'd0);
        chk("t7_instruction", bus.instruction, 32'd0);
        chk("t7_instr_id", 32'(bus.instr_id), 32'd0);
        chk("t7_cnt", 32'(bus.outstanding_cnt), 32'd0);
        chk("t7_spur", 32'(bus.spurious_result), 32'd0);
        chk("t7_idle", 32'(bus.idle), 32'd1);
        chk("t7_in_ready", 32'(bus.in_ready), 32'd1);
        model_reset();
        @(posedge ck);
        #1;
        rst = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            ins = $urandom;
            fl  = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = 1'b0;
            rid = '0;
            if (m_out.size() > 0 && $urandom_range(0, 2) == 0) begin
                rv  = 1'b1;
                rid = 4'(m_out[$urandom_range(0, m_out.size() - 1)]);
            end else if ($urandom_range(0, 99) == 0) begin
                rv  = 1'b1;
                rid = 4'($urandom);
            end
            cyc(v, ins, fl, rdy, rv, rid);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
